sgpr_wb_buffer: RTL and testbench
=================================

SGPR_WB_BUFFER -- requirements
Module: sgpr_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports a_valid/a_ready, input/output, 1/1, source A (ALU) handshake.
REQ-005 SHALL have ports a_addr/a_en/a_data, input, 9/2/64, source A SGPR address, dword enable, data.
REQ-006 SHALL have ports b_valid/b_ready, input/output, 1/1, source B (LSU) handshake.
REQ-007 SHALL have ports b_addr/b_en/b_data, input, 9/4/128, source B address, dword enable, data.
REQ-008 SHALL have port wr_stall, input, 1, write port unavailable next cycle.
REQ-009 SHALL have ports wr0_addr/wr0_en/wr0_data, output, 9/4/128, registered drive of the register file's 128/64/32-bit write port.
REQ-010 SHALL have ports empty/level, output, 1/log2(DEPTH)+1, idle flag and FIFO occupancy.
REQ-011 SHALL have ports err_misalign/drop_cnt, output, 1/8, sticky error flag and dropped-request count.

Function
REQ-012 SHALL be a transfer on a source when valid and ready are both high at a rising edge; at most one transfer per cycle in total.
REQ-013 SHALL assert a_ready/b_ready only when level < DEPTH and the arbiter grants that source; ready SHALL NOT depend on a same-cycle pop (no full pass-through).
REQ-014 SHALL arbitrate round-robin: after reset A has priority; after each grant with both valid, priority moves to the other source; a lone requester is always granted.
REQ-015 SHALL treat as legal: A en 01 any addr; A en 11 with addr[0]=0; B en 0001 any addr; B en 0011 with addr[0]=0; B en 1111 with addr[1:0]=00.
REQ-016 SHALL accept (ready high) but not enqueue any illegal request with nonzero en, set err_misalign, and increment drop_cnt saturating at 255.
REQ-017 SHALL accept and silently discard requests with en all-zero (no error, no count).
REQ-018 SHALL enqueue A entries as en {00,a_en}, data {64'h0,a_data}; B entries unchanged.
REQ-019 SHALL pop the head entry at an edge when level > 0 and wr_stall is low, loading wr0_addr/wr0_en/wr0_data from it.
REQ-020 SHALL drive wr0_en = 0000 in any cycle following an edge with no pop; wr0_addr/wr0_data then hold their last values.
REQ-021 SHALL give latency: transfer at edge N into empty FIFO, wr_stall low in cycle N+1 -> write presented in cycle N+2, for exactly one cycle.
REQ-022 SHALL preserve global acceptance order on wr0 outputs.
REQ-023 SHALL allow simultaneous push and pop in one cycle, level unchanged.
REQ-024 SHALL drive empty high iff level = 0 and wr0_en = 0000.
REQ-025 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-026 SHALL on rst_n low immediately clear: level 0, pointers 0, wr0_en 0000, wr0_addr 0, wr0_data 0, err_misalign 0, drop_cnt 0, priority to A, a_ready/b_ready 0.
REQ-027 SHALL discard all queued entries on reset mid-operation; no write presented in the cycle after rst_n deasserts.

Verification
REQ-028 SHALL cover: B push addr 0x010 en 1111 data D, wr_stall 0 -> cycle N+2 wr0_addr 0x010, wr0_en 1111, wr0_data D; next cycle wr0_en 0000, empty 1.
REQ-029 SHALL cover: A and B valid every cycle, wr_stall 0 -> grants alternate A,B,A,B; wr0 output order matches.
REQ-030 SHALL cover: wr_stall held high, 5 B pushes with DEPTH 4 -> 4 accepted, b_ready low on 5th, level 4; release stall -> 4 writes in order on consecutive cycles.
REQ-031 SHALL cover: B en 0011 addr 0x003, then A en 11 addr 0x005 -> both dropped, err_misalign 1, drop_cnt 2, level 0, no write presented.
REQ-032 SHALL cover: 3 entries queued, rst_n pulsed low mid-cycle -> outputs zero immediately, level 0, no write after release, first new push appears at N+2.

Source files
------------

// File: rtl/sgpr_wb_buffer.sv
// Scalar register write-back buffer: merges ALU and LSU write requests through a
// round-robin arbiter into a small FIFO that drives the SGPR file's single write port.
module sgpr_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [8:0]                 a_addr,
    input  logic [1:0]                 a_en,
    input  logic [63:0]                a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [8:0]                 b_addr,
    input  logic [3:0]                 b_en,
    input  logic [127:0]               b_data,
    input  logic                       wr_stall,
    output logic [8:0]                 wr0_addr,
    output logic [3:0]                 wr0_en,
    output logic [127:0]               wr0_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err_misalign,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [8:0]    mem_addr [DEPTH];
    logic [3:0]    mem_en   [DEPTH];
    logic [127:0]  mem_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          prio_b;

    logic          grant_a;
    logic          grant_b;
    logic          a_legal;
    logic          b_legal;
    logic [8:0]    in_addr;
    logic [3:0]    in_en;
    logic [127:0]  in_data;
    logic          in_legal;
    logic          push;
    logic          drop;
    logic          pop;

    // Ready never looks at the pop path, so a full FIFO blocks even when draining.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (rst_n && (level < LVL_FULL)) begin
            if (a_valid && b_valid) begin
                grant_a = ~prio_b;
                grant_b = prio_b;
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign a_legal = (a_en == 2'b01) || ((a_en == 2'b11) && !a_addr[0]);
    assign b_legal = (b_en == 4'b0001)
                  || ((b_en == 4'b0011) && !b_addr[0])
                  || ((b_en == 4'b1111) && (b_addr[1:0] == 2'b00));

    always_comb begin
        in_addr  = b_addr;
        in_en    = b_en;
        in_data  = b_data;
        in_legal = b_legal;
        if (grant_a) begin
            in_addr  = a_addr;
            in_en    = {2'b00, a_en};
            in_data  = {64'h0, a_data};
            in_legal = a_legal;
        end
    end

    // Zero-enable requests are legal no-ops: neither queued nor counted.
    assign push = (grant_a || grant_b) && in_legal;
    assign drop = (grant_a || grant_b) && !in_legal && (in_en != 4'b0000);
    assign pop  = (level != '0) && !wr_stall;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_en[wr_ptr]   <= in_en;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            prio_b       <= 1'b0;
            wr0_addr     <= '0;
            wr0_en       <= '0;
            wr0_data     <= '0;
            err_misalign <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            if (a_valid && b_valid && (grant_a || grant_b)) begin
                prio_b <= grant_a;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                wr0_addr <= mem_addr[rd_ptr];
                wr0_en   <= mem_en[rd_ptr];
                wr0_data <= mem_data[rd_ptr];
            end else begin
                wr0_en <= 4'b0000;
            end
            if (drop) begin
                err_misalign <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    assign empty = (level == '0) && (wr0_en == 4'b0000);

endmodule

// File: tb/tb_sgpr_wb_buffer.sv
// Directed bench for sgpr_wb_buffer: hand-written vectors with an in-order
// expected-write queue that every presented write is compared against.
module tb_sgpr_wb_buffer;

    logic         clk;
    logic         rst_n;
    logic         a_valid;
    logic         a_ready;
    logic [8:0]   a_addr;
    logic [1:0]   a_en;
    logic [63:0]  a_data;
    logic         b_valid;
    logic         b_ready;
    logic [8:0]   b_addr;
    logic [3:0]   b_en;
    logic [127:0] b_data;
    logic         wr_stall;
    logic [8:0]   wr0_addr;
    logic [3:0]   wr0_en;
    logic [127:0] wr0_data;
    logic         empty;
    logic [2:0]   level;
    logic         err_misalign;
    logic [7:0]   drop_cnt;

    typedef struct packed {
        logic [8:0]   addr;
        logic [3:0]   en;
        logic [127:0] data;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   n_chk;
    int   n_bad;

    sgpr_wb_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_en         (a_en),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_en         (b_en),
        .b_data       (b_data),
        .wr_stall     (wr_stall),
        .wr0_addr     (wr0_addr),
        .wr0_en       (wr0_en),
        .wr0_data     (wr0_data),
        .empty        (empty),
        .level        (level),
        .err_misalign (err_misalign),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every presented write must be the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (rst_n && (wr0_en != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 128'(wr0_en), 128'h0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 128'(wr0_addr), 128'(mon_e.addr));
                chk("wr_en", 128'(wr0_en), 128'(mon_e.en));
                chk("wr_data", wr0_data, mon_e.data);
            end
        end
    end

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        a_valid  = 1'b1;
        a_addr   = '0;
        a_en     = 2'b01;
        a_data   = '0;
        b_valid  = 1'b0;
        b_addr   = '0;
        b_en     = '0;
        b_data   = '0;
        wr_stall = 1'b0;

        #12;
        chk("rst_level", 128'(level), 128'h0);
        chk("rst_wr0_en", 128'(wr0_en), 128'h0);
        chk("rst_empty", 128'(empty), 128'h1);
        chk("rst_a_ready", 128'(a_ready), 128'h0);
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // single B push, latency and one-cycle write
        @(negedge clk);
        b_valid = 1'b1; b_addr = 9'h010; b_en = 4'b1111;
        b_data  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        #1 chk("t1_b_ready", 128'(b_ready), 128'h1);
        exp_q.push_back('{9'h010, 4'b1111, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210});
        @(negedge clk);
        b_valid = 1'b0;
        chk("t1_level_n1", 128'(level), 128'h1);
        chk("t1_no_wr_n1", 128'(wr0_en), 128'h0);
        @(negedge clk);
        chk("t1_wr_addr", 128'(wr0_addr), 128'h010);
        chk("t1_wr_en", 128'(wr0_en), 128'hF);
        chk("t1_wr_data", wr0_data, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        chk("t1_not_empty", 128'(empty), 128'h0);
        @(negedge clk);
        chk("t1_en_off", 128'(wr0_en), 128'h0);
        chk("t1_empty", 128'(empty), 128'h1);
        chk("t1_addr_hold", 128'(wr0_addr), 128'h010);

        // both sources every cycle: A,B,A,B
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_addr = 9'h020 + 9'(i); a_en = 2'b01; a_data = 64'hA0 + 64'(i);
            b_valid = 1'b1; b_addr = 9'h040 + 9'(4 * i); b_en = 4'b1111; b_data = 128'hB0 + 128'(i);
            #1;
            if (i % 2 == 0) begin
                chk("t2_a_grant", 128'(a_ready), 128'h1);
                chk("t2_b_wait", 128'(b_ready), 128'h0);
                exp_q.push_back('{9'h020 + 9'(i), 4'b0001, 128'hA0 + 128'(i)});
            end else begin
                chk("t2_a_wait", 128'(a_ready), 128'h0);
                chk("t2_b_grant", 128'(b_ready), 128'h1);
                exp_q.push_back('{9'h040 + 9'(4 * i), 4'b1111, 128'hB0 + 128'(i)});
            end
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_drain", 128'(exp_q.size()), 128'h0);

        // stall, fill to DEPTH, fifth refused, then burst drain
        wr_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_valid = 1'b1; b_addr = 9'h100 + 9'(i); b_en = 4'b0001; b_data = 128'h300 + 128'(i);
            #1;
            if (i < 4) begin
                chk("t3_b_ready", 128'(b_ready), 128'h1);
                exp_q.push_back('{9'h100 + 9'(i), 4'b0001, 128'h300 + 128'(i)});
            end else begin
                chk("t3_full_block", 128'(b_ready), 128'h0);
                chk("t3_level_full", 128'(level), 128'h4);
            end
        end
        wr_stall = 1'b0;
        #1 chk("t3_no_passthru", 128'(b_ready), 128'h0);
        @(negedge clk);
        b_valid = 1'b0;
        chk("t3_burst0", 128'(wr0_en), 128'h1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("t3_burst", 128'(wr0_en), 128'h1);
        end
        @(negedge clk);
        chk("t3_done_en", 128'(wr0_en), 128'h0);
        chk("t3_done_empty", 128'(empty), 128'h1);
        chk("t3_drain", 128'(exp_q.size()), 128'h0);

        // misaligned drops, zero-enable discard, legal A pair
        @(negedge clk);
        b_valid = 1'b1; b_addr = 9'h003; b_en = 4'b0011; b_data = 128'hDEAD;
        #1 chk("t4_b_accept", 128'(b_ready), 128'h1);
        @(negedge clk);
        b_valid = 1'b0;
        a_valid = 1'b1; a_addr = 9'h005; a_en = 2'b11; a_data = 64'hBEEF;
        #1 chk("t4_a_accept", 128'(a_ready), 128'h1);
        @(negedge clk);
        chk("t4_err", 128'(err_misalign), 128'h1);
        chk("t4_drop2", 128'(drop_cnt), 128'h2);
        chk("t4_level0", 128'(level), 128'h0);
        a_addr = 9'h006; a_en = 2'b00;
        #1 chk("t4_zero_accept", 128'(a_ready), 128'h1);
        @(negedge clk);
        chk("t4_zero_nocount", 128'(drop_cnt), 128'h2);
        chk("t4_zero_level", 128'(level), 128'h0);
        chk("t4_no_wr", 128'(wr0_en), 128'h0);
        a_addr = 9'h004; a_en = 2'b11; a_data = 64'h1234_5678_9abc_def0;
        exp_q.push_back('{9'h004, 4'b0011, {64'h0, 64'h1234_5678_9abc_def0}});
        @(negedge clk);
        a_addr = 9'h007; a_en = 2'b10;
        @(negedge clk);
        a_valid = 1'b0;
        chk("t4_drop3", 128'(drop_cnt), 128'h3);
        repeat (2) @(negedge clk);
        chk("t4_drain", 128'(exp_q.size()), 128'h0);

        // reset with entries queued
        wr_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_valid = 1'b1; b_addr = 9'h080 + 9'(4 * i); b_en = 4'b1111; b_data = 128'hC0 + 128'(i);
            exp_q.push_back('{9'h080 + 9'(4 * i), 4'b1111, 128'hC0 + 128'(i)});
        end
        @(negedge clk);
        b_valid = 1'b0;
        chk("t5_level3", 128'(level), 128'h3);
        wr_stall = 1'b0;
        @(negedge clk);
        chk("t5_pre_rst_wr", 128'(wr0_en), 128'hF);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_en", 128'(wr0_en), 128'h0);
        chk("t5_rst_addr", 128'(wr0_addr), 128'h0);
        chk("t5_rst_data", wr0_data, 128'h0);
        chk("t5_rst_level", 128'(level), 128'h0);
        chk("t5_rst_err", 128'(err_misalign), 128'h0);
        chk("t5_rst_drop", 128'(drop_cnt), 128'h0);
        chk("t5_rst_empty", 128'(empty), 128'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_post_no_wr", 128'(wr0_en), 128'h0);
        chk("t5_post_level", 128'(level), 128'h0);
        b_valid = 1'b1; b_addr = 9'h0C0; b_en = 4'b1111; b_data = 128'hE0E0;
        exp_q.push_back('{9'h0C0, 4'b1111, 128'hE0E0});
        #1 chk("t5_new_ready", 128'(b_ready), 128'h1);
        @(negedge clk);
        b_valid = 1'b0;
        chk("t5_new_n1", 128'(wr0_en), 128'h0);
        @(negedge clk);
        chk("t5_new_en", 128'(wr0_en), 128'hF);
        chk("t5_new_addr", 128'(wr0_addr), 128'h0C0);
        @(negedge clk);
        chk("t5_drain", 128'(exp_q.size()), 128'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
